fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_skid.sv | 52 +++++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, NOP
// encoding, reset PC and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int INTERNAL_BITS = 32;

  localparam logic [INTERNAL_BITS-1:0] NOP      = '0;
  localparam logic [INTERNAL_BITS-1:0] RESET_PC = '0;
  localparam logic [INTERNAL_BITS-1:0] PC_STEP  = 4;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that parks a fetched word and its PC+4 while the
// IF/ID register is stalled.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     clear,
  input  logic [INTERNAL_BITS-1:0] load_data,
  input  logic [INTERNAL_BITS-1:0] load_pc4,
  output logic [INTERNAL_BITS-1:0] data,
  output logic [INTERNAL_BITS-1:0] pc4,
  output logic                     full
);

  logic [INTERNAL_BITS-1:0] data_q, data_d;
  logic [INTERNAL_BITS-1:0] pc4_q, pc4_d;
  logic                     full_q, full_d;

  always_comb begin
    data_d = data_q;
    pc4_d  = pc4_q;
    full_d = full_q;
    if (load) begin
      data_d = load_data;
      pc4_d  = load_pc4;
      full_d = 1'b1;
    end else if (clear) begin
      data_d = '0;
      pc4_d  = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pc4_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pc4_q  <= pc4_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign pc4  = pc4_q;
  assign full = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory and fills the IF/ID register, with stall skid, redirect and halt.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [INTERNAL_BITS-1:0] redirect_pc,
  input  logic                     done,
  output logic                     im_req,
  output logic [INTERNAL_BITS-1:0] im_addr,
  input  logic                     im_ack,
  input  logic [INTERNAL_BITS-1:0] im_rdata,
  output logic [INTERNAL_BITS-1:0] if_instr,
  output logic [INTERNAL_BITS-1:0] if_pc4,
  output logic                     if_valid
);

  fetch_state_e state_q, state_d;
  logic [INTERNAL_BITS-1:0] pc_q, pc_d;
  logic [INTERNAL_BITS-1:0] req_addr_q, req_addr_d;
  logic [INTERNAL_BITS-1:0] if_instr_q, if_instr_d;
  logic [INTERNAL_BITS-1:0] if_pc4_q, if_pc4_d;
  logic                     if_valid_q, if_valid_d;
  logic                     halt_pending_q, halt_pending_d;
  logic                     skid_load, skid_clear, skid_full;
  logic [INTERNAL_BITS-1:0] skid_data, skid_pc4;
  logic [INTERNAL_BITS-1:0] seq_pc;

  assign seq_pc = req_addr_q + PC_STEP;

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (im_rdata),
    .load_pc4  (seq_pc),
    .data      (skid_data),
    .pc4       (skid_pc4),
    .full      (skid_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      req_addr_q     <= '0;
      if_instr_q     <= NOP;
      if_pc4_q       <= '0;
      if_valid_q     <= 1'b0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      req_addr_q     <= req_addr_d;
      if_instr_q     <= if_instr_d;
      if_pc4_q       <= if_pc4_d;
      if_valid_q     <= if_valid_d;
      halt_pending_q <= halt_pending_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_addr_d     = req_addr_q;
    if_instr_d     = if_instr_q;
    if_pc4_d       = if_pc4_q;
    if_valid_d     = if_valid_q;
    halt_pending_d = halt_pending_q | done;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    // Priority inside each state: done, then redirect, then stall.
    case (state_q)
      BOOT: state_d = done ? HALT : REQ;
      REQ: begin
        if (done) begin
          state_d = im_ack ? HALT : DRAIN;
        end else if (redirect) begin
          pc_d = redirect_pc;
          if (!im_ack) state_d = DRAIN;
        end else if (im_ack) begin
          pc_d = seq_pc;
          if (stall) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else begin
            if_instr_d = im_rdata;
            if_pc4_d   = seq_pc;
            if_valid_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (done) begin
          skid_clear = 1'b1;
          state_d    = HALT;
        end else if (redirect) begin
          pc_d       = redirect_pc;
          skid_clear = 1'b1;
          state_d    = REQ;
        end else if (!stall) begin
          if_instr_d = skid_data;
          if_pc4_d   = skid_pc4;
          if_valid_d = skid_full;
          skid_clear = 1'b1;
          state_d    = REQ;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (im_ack) state_d = halt_pending_d ? HALT : REQ;
      end
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
    // A fresh request starts whenever REQ is entered or the previous one completes.
    if (state_d == REQ && (state_q != REQ || im_ack)) req_addr_d = pc_d;
    if (flush) begin
      if_instr_d = NOP;
      if_pc4_d   = if_pc4_q;
      if_valid_d = 1'b0;
    end
    if (state_d == HALT) begin
      if_instr_d = NOP;
      if_valid_d = 1'b0;
    end
  end

  always_comb begin
    im_req = (state_q == REQ) || (state_q == DRAIN);
  end

  assign im_addr  = req_addr_q;
  assign if_instr = if_instr_q;
  assign if_pc4   = if_pc4_q;
  assign if_valid = if_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic against a queue-based behavioural model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect, done;
  logic [31:0] redirect_pc;
  logic        im_req, im_ack, if_valid;
  logic [31:0] im_addr, im_rdata, if_instr, if_pc4;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;
  int mem_lat  = 0;
  int mem_lat_fixed = 0;

  logic        m_boot, m_halted, m_active, m_discard, m_halt_pend;
  logic [31:0] m_pc, m_addr, e_instr, e_pc4;
  logic        e_valid;
  logic [63:0] m_buf[$];

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .if_instr    (if_instr),
    .if_pc4      (if_pc4),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  // Memory: acks after mem_lat waiting cycles, word = address >> 2.
  assign im_ack   = im_req && (mem_cnt >= mem_lat);
  assign im_rdata = im_addr >> 2;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    m_boot = 1'b1; m_halted = 1'b0; m_active = 1'b0; m_discard = 1'b0;
    m_halt_pend = 1'b0; m_pc = 32'h0; m_addr = 32'h0;
    e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
    m_buf.delete();
  endtask

  // Fetch stream model: one outstanding request (possibly marked for discard)
  // and a queue holding at most one parked instruction.
  task automatic modelStep(input logic s, input logic f, input logic r,
                           input logic [31:0] rp, input logic d, input logic ack);
    logic        hp, load;
    logic [63:0] ent;
    hp = m_halt_pend | d;
    load = 1'b0;
    ent = 64'h0;
    if (!m_halted) begin
      if (m_boot) begin
        m_boot = 1'b0;
        if (d) m_halted = 1'b1;
        else begin m_active = 1'b1; m_addr = m_pc; end
      end else if (m_buf.size() != 0) begin
        if (d) begin
          m_halted = 1'b1; m_buf.delete();
        end else if (r) begin
          m_pc = rp; m_buf.delete(); m_active = 1'b1; m_addr = m_pc;
        end else if (!s) begin
          ent = m_buf.pop_front(); load = 1'b1; m_active = 1'b1; m_addr = m_pc;
        end
      end else if (m_active && m_discard) begin
        if (r) m_pc = rp;
        if (ack) begin
          m_discard = 1'b0;
          if (hp) m_halted = 1'b1;
          else m_addr = m_pc;
        end
      end else if (m_active) begin
        if (d) begin
          if (ack) m_halted = 1'b1;
          else m_discard = 1'b1;
        end else if (r) begin
          m_pc = rp;
          if (ack) m_addr = m_pc;
          else m_discard = 1'b1;
        end else if (ack) begin
          m_pc = m_addr + 32'd4;
          ent = {m_addr >> 2, m_pc};
          if (s) begin
            m_buf.push_back(ent); m_active = 1'b0;
          end else begin
            load = 1'b1; m_addr = m_pc;
          end
        end
      end
    end
    if (m_halted) begin
      m_active = 1'b0; e_instr = 32'h0; e_valid = 1'b0;
    end else if (f) begin
      e_instr = 32'h0; e_valid = 1'b0;
    end else if (load) begin
      e_instr = ent[63:32]; e_pc4 = ent[31:0]; e_valid = 1'b1;
    end
    m_halt_pend = hp;
  endtask

  task automatic compareModel();
    checkOutput("im_req", 32'(im_req), 32'(m_active));
    if (m_active) checkOutput("im_addr", im_addr, m_addr);
    checkOutput("if_instr", if_instr, e_instr);
    checkOutput("if_pc4", if_pc4, e_pc4);
    checkOutput("if_valid", 32'(if_valid), 32'(e_valid));
  endtask

  task automatic nextLatency();
    mem_lat = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 3));
  endtask

  // One clock cycle: drive inputs after the falling edge, predict, check on the next falling edge.
  task automatic applyStimulus(input logic s, input logic f, input logic r,
                               input logic [31:0] rp, input logic d);
    logic ack, req;
    int   nc;
    stall = s; flush = f; redirect = r; redirect_pc = rp; done = d;
    #1;
    ack = im_ack;
    req = im_req;
    nc = (req && !ack) ? mem_cnt + 1 : 0;
    modelStep(s, f, r, rp, d, ack);
    @(posedge clk);
    #1;
    mem_cnt = nc;
    if (nc == 0) nextLatency();
    @(negedge clk);
    compareModel();
  endtask

  task automatic doReset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; done = 1'b0;
    @(posedge clk);
    #1;
    mem_cnt = 0;
    nextLatency();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    compareModel();
    checkOutput("rst_im_addr", im_addr, 32'h0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] rp;
    rst = 1'b1;
    mem_lat_fixed = 0;
    doReset();

    // Zero-wait streaming, then a stall that parks word 2 in the skid.
    idle();  checkOutput("seq_addr0", im_addr, 32'h0);
    idle();  checkOutput("seq_addr4", im_addr, 32'h4);
    checkOutput("seq_instr0", if_instr, 32'h0); checkOutput("seq_pc4_4", if_pc4, 32'h4);
    idle();  checkOutput("seq_addr8", im_addr, 32'h8);
    checkOutput("seq_instr1", if_instr, 32'h1); checkOutput("seq_pc4_8", if_pc4, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_req_low", 32'(im_req), 32'h0); checkOutput("stall_hold", if_instr, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_req_low2", 32'(im_req), 32'h0);
    idle();
    checkOutput("skid_instr2", if_instr, 32'h2); checkOutput("skid_pc4_12", if_pc4, 32'hC);
    checkOutput("skid_addr12", im_addr, 32'hC);

    // Three-cycle memory, redirect while the request to 4 is outstanding.
    mem_lat_fixed = 2;
    doReset();
    repeat (4) idle();
    checkOutput("lat_addr4", im_addr, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    checkOutput("drain_addr4", im_addr, 32'h4);
    idle();  checkOutput("drain_hold", im_addr, 32'h4);
    idle();  checkOutput("drain_to_100", im_addr, 32'h100);
    checkOutput("drain_discard", if_instr, 32'h0);

    // Flush plus redirect in an ack cycle.
    mem_lat_fixed = 0;
    doReset();
    idle(); idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    checkOutput("flush_valid", 32'(if_valid), 32'h0); checkOutput("flush_nop", if_instr, 32'h0);
    checkOutput("flush_addr40", im_addr, 32'h40);
    idle();  checkOutput("flush_next", if_instr, 32'h10);

    // Halt during a two-cycle request.
    mem_lat_fixed = 1;
    doReset();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      checkOutput("halt_req", 32'(im_req), 32'h0);
    end

    // PC wrap, then asynchronous reset in the middle of a request.
    mem_lat_fixed = 0;
    doReset();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("wrap_addr", im_addr, 32'hFFFF_FFFC);
    idle();
    checkOutput("wrap_next", im_addr, 32'h0); checkOutput("wrap_pc4", if_pc4, 32'h0);
    mem_lat_fixed = 3;
    idle(); idle();
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_req", 32'(im_req), 32'h0);
    checkOutput("arst_addr", im_addr, 32'h0);
    checkOutput("arst_instr", if_instr, 32'h0);
    checkOutput("arst_pc4", if_pc4, 32'h0);
    checkOutput("arst_valid", 32'(if_valid), 32'h0);
    doReset();

    // Randomized traffic with variable memory latency.
    mem_lat_fixed = -1;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 299) begin
        doReset();
      end else begin
        case ($urandom_range(0, 3))
          0: rp = $urandom & 32'hFFFF_FFFC;
          1: rp = $urandom;
          2: rp = 32'hFFFF_FFFC;
          default: rp = 32'($urandom_range(0, 255));
        endcase
        applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 1,
                      $urandom_range(0, 9) < 1, rp, $urandom_range(0, 99) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
